// File: rtl/map_scroll_pkg.sv
// map_scroll_pkg: shared constants and helper functions for the map scroll timer.
// Holds the default period curve, the level-saturation rule and the
// level -> period function (clamped, never zero).
package map_scroll_pkg;

  localparam int DEF_LEVELS     = 8;
  localparam int DEF_P_SLOW     = 75;
  localparam int DEF_P_STEP     = 9;
  localparam int DEF_P_MIN      = 12;
  localparam int DEF_RAMP_TICKS = 20000;
  localparam int DEF_BASE_MAX   = 3;

  // Scroll period in enabled ticks for a given level: linear descent from
  // p_slow, floored at p_min, and never allowed to reach zero.
  function automatic int period_of(input int lvl, input int p_slow,
                                   input int p_step, input int p_min);
    int p;
    p = p_slow - lvl * p_step;
    if (p < p_min) p = p_min;
    if (p < 1) p = 1;
    return p;
  endfunction

  // Clamp a base+velocity sum to the highest legal level index.
  function automatic int sat_level(input int sum, input int levels);
    return (sum > levels - 1) ? levels - 1 : sum;
  endfunction

endpackage

// File: rtl/map_scroll_pwm.sv
// map_scroll_pwm: velocimeter PWM generator. A free-running frame counter
// compares against a high-width that is only reloaded at the frame wrap, so
// a level change never produces a truncated or glitch pulse mid-frame.
// Only instantiated when MAP_SCROLL_PWM_EN is defined.
module map_scroll_pwm #(
  parameter int LVL_W      = 3,
  parameter int PWM_PERIOD = 1000,
  parameter int PWM_MIN    = 35,
  parameter int PWM_STEP   = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic [LVL_W-1:0] level,
  output logic             pwm
);

  localparam int CNT_W = $clog2(PWM_PERIOD + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(PWM_PERIOD - 1);

  logic [CNT_W-1:0] frame_reg;
  logic [CNT_W-1:0] width_reg;
  logic [CNT_W-1:0] width_next;

  assign width_next = CNT_W'(PWM_MIN + int'(level) * PWM_STEP);

  // Frame counter runs on every clock; width is captured only at the wrap.
  // After reset the first frame stays dark because width starts at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_reg <= '0;
      width_reg <= '0;
    end else if (restart) begin
      frame_reg <= '0;
      width_reg <= '0;
    end else if (frame_reg == FRAME_LAST) begin
      frame_reg <= '0;
      width_reg <= width_next;
    end else begin
      frame_reg <= frame_reg + CNT_W'(1);
    end
  end

  assign pwm = (frame_reg < width_reg);

endmodule

// File: rtl/map_scroll_timer.sv
// map_scroll_timer: single elapsed-tick counter compared against a period
// derived from the effective level (ramp base + player velocity), so a speed
// change takes effect immediately without losing a scroll step.
// Optional velocimeter PWM output enabled by defining MAP_SCROLL_PWM_EN.
module map_scroll_timer import map_scroll_pkg::*; #(
  parameter int LEVELS     = DEF_LEVELS,
  parameter int LVL_W      = 3,
  parameter int PLAYER_W   = 2,
  parameter int PERIOD_W   = 16,
  parameter int P_SLOW     = DEF_P_SLOW,
  parameter int P_STEP     = DEF_P_STEP,
  parameter int P_MIN      = DEF_P_MIN,
  parameter int RAMP_TICKS = DEF_RAMP_TICKS,
  parameter int BASE_MAX   = DEF_BASE_MAX
`ifdef MAP_SCROLL_PWM_EN
  ,
  parameter int PWM_PERIOD = 1000,
  parameter int PWM_MIN    = 35,
  parameter int PWM_STEP   = 10
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                restart,
  input  logic                count_map,
  input  logic [PLAYER_W-1:0] velocity,
  output logic                move_map,
  output logic [LVL_W-1:0]    level,
  output logic [LVL_W-1:0]    base_level,
  output logic                max_base,
  output logic                pwm
);

  localparam int RAMP_W = $clog2(RAMP_TICKS + 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);
  localparam logic [LVL_W-1:0]  BASE_TOP  = LVL_W'(BASE_MAX);

  logic [PERIOD_W-1:0] elapsed_reg;
  logic [RAMP_W-1:0]   ramp_reg;
  logic [RAMP_W-1:0]   ramp_next;
  logic [LVL_W-1:0]    base_reg;
  logic [LVL_W-1:0]    base_next;
  logic [LVL_W-1:0]    level_reg;
  logic                move_reg;
  logic                max_reg;

  logic [LVL_W:0]      lvl_sum;
  logic [LVL_W-1:0]    eff_level;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W:0]   elapsed_inc;
  logic                period_done;

  // Effective level and its period; one extra bit keeps the sum from wrapping
  // before it is saturated, and the compare is done one bit wider as well.
  always_comb begin
    lvl_sum     = (LVL_W+1)'(base_reg) + (LVL_W+1)'(velocity);
    eff_level   = LVL_W'(sat_level(int'(lvl_sum), LEVELS));
    period      = PERIOD_W'(period_of(int'(eff_level), P_SLOW, P_STEP, P_MIN));
    elapsed_inc = {1'b0, elapsed_reg} + (PERIOD_W+1)'(1);
    period_done = (elapsed_inc >= {1'b0, period});
  end

  // Difficulty ramp: base level climbs every RAMP_TICKS enabled ticks until it
  // saturates, after which the ramp counter parks at zero.
  always_comb begin
    ramp_next = ramp_reg;
    base_next = base_reg;
    if (count_map && (base_reg < BASE_TOP)) begin
      if (ramp_reg == RAMP_LAST) begin
        ramp_next = '0;
        base_next = base_reg + LVL_W'(1);
      end else begin
        ramp_next = ramp_reg + RAMP_W'(1);
      end
    end
  end

  // State update: scroll counter, ramp, and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      elapsed_reg <= '0;
      ramp_reg    <= '0;
      base_reg    <= '0;
      level_reg   <= '0;
      move_reg    <= 1'b0;
      max_reg     <= 1'b0;
    end else if (restart) begin
      elapsed_reg <= '0;
      ramp_reg    <= '0;
      base_reg    <= '0;
      level_reg   <= '0;
      move_reg    <= 1'b0;
      max_reg     <= 1'b0;
    end else begin
      level_reg <= eff_level;
      ramp_reg  <= ramp_next;
      base_reg  <= base_next;
      max_reg   <= (base_next == BASE_TOP);
      if (count_map) begin
        if (period_done) begin
          elapsed_reg <= '0;
          move_reg    <= 1'b1;
        end else begin
          elapsed_reg <= elapsed_inc[PERIOD_W-1:0];
          move_reg    <= 1'b0;
        end
      end else begin
        move_reg <= 1'b0;
      end
    end
  end

  assign move_map   = move_reg;
  assign level      = level_reg;
  assign base_level = base_reg;
  assign max_base   = max_reg;

`ifdef MAP_SCROLL_PWM_EN
  map_scroll_pwm #(
    .LVL_W      (LVL_W),
    .PWM_PERIOD (PWM_PERIOD),
    .PWM_MIN    (PWM_MIN),
    .PWM_STEP   (PWM_STEP)
  ) u_pwm (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .level   (level_reg),
    .pwm     (pwm)
  );
`else
  assign pwm = 1'b0;
`endif

endmodule

// File: doc/map_scroll_timer.md
Name: map_scroll_timer

Overview:
- Parametrised successor to the delivery-game map timing block.
- Replaces the bank of fixed per-speed counters with a single elapsed-tick counter compared against a computed period, so a player velocity change never drops or delays a scroll step.
- Generalised to N speed levels with a configurable period curve, difficulty ramp, restart and status outputs.
- Sits between the game FSM (count_map enable, 1 kHz tick domain) and the map RAM scroller (consumes move_map).

Parameters:
- LEVELS, 8, number of speed levels; level index 0..LEVELS-1, 0 = slowest.
- LVL_W, 3, width of level fields; must satisfy 2^LVL_W >= LEVELS.
- PLAYER_W, 2, width of the player velocity input.
- PERIOD_W, 16, width of the elapsed counter and period values.
- P_SLOW, 75, period in enabled ticks at level 0.
- P_STEP, 9, period decrement per level.
- P_MIN, 12, period floor.
- RAMP_TICKS, 20000, enabled ticks per base-level increment (20 s at 1 kHz).
- BASE_MAX, 3, saturation value of base level.
- PWM_PERIOD, 1000, PWM frame length in clock cycles (optional feature only).
- PWM_MIN, 35, PWM high width at level 0 (optional feature only).
- PWM_STEP, 10, extra PWM high width per level (optional feature only).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous clear at new game; same effect as reset.
- count_map  in  1  enable; the block advances only when high.
- velocity  in  PLAYER_W  player speed offset, synchronous to clock.
- move_map  out  1  one-cycle scroll pulse, registered.
- level  out  LVL_W  current effective level, registered.
- base_level  out  LVL_W  current ramp base level, registered.
- max_base  out  1  high while base_level == BASE_MAX.
- pwm  out  1  velocimeter drive; constant 0 when the optional feature is off.

Behaviour:
- Reset (async, reset low) or restart high: elapsed=0, ramp=0, base_level=0, move_map=0, level=0, max_base=0, pwm=0. restart wins over count_map in the same cycle.
- Effective level L (combinational) = min(base_level + velocity, LEVELS-1). The sum is computed at LVL_W+1 bits, then saturated.
- Period P(L) = max(P_MIN, P_SLOW - L*P_STEP), computed signed and clamped; never 0. With defaults: 75, 66, 57, 48, 39, 30, 21, 12.
- Each edge with count_map=1:
  - if elapsed+1 >= P(L): elapsed<=0, move_map<=1;
  - else elapsed<=elapsed+1, move_map<=0.
- Any edge with count_map=0: elapsed holds, move_map<=0.
- Latency: move_map is high for exactly one cycle, immediately after the edge that sampled the P-th enabled tick.
- Velocity change mid-count: the comparison uses the new P at once.
  - If elapsed already >= new P-1, the pulse fires on the next enabled edge. No pulse is ever lost.
  - At most one pulse per enabled edge.
- Ramp: ramp increments on count_map. When ramp reaches RAMP_TICKS-1 and an enabled edge occurs, ramp<=0 and base_level<=base_level+1, saturating at BASE_MAX.
  - When saturated, ramp holds at 0.
  - max_base is registered from the next base_level value.
- level output is L registered each cycle, including cycles with count_map=0.
- A ramp increment and a scroll pulse on the same edge are independent. That edge's pulse uses the pre-increment base_level.

Optional Feature:
- MAP_SCROLL_PWM_EN defined: pwm frame counter 0..PWM_PERIOD-1 runs freely on clock; count_map does not gate it.
  - pwm=1 while frame counter < PWM_MIN + level*PWM_STEP.
  - The new width is latched at frame start only, so there are no glitch pulses.
- Not defined: pwm tied to 0 and no PWM logic is synthesised.

Decomposition:
- Package map_scroll_pkg holds the period-curve function (level -> period with clamp), the level saturate function and default curve constants.
- Natural sub-module: map_scroll_pwm (frame counter plus latched width compare), instantiated only under MAP_SCROLL_PWM_EN.

Test Plan:
- Reset then count_map=1, velocity=0 -> first move_map after 75 enabled cycles, then every 75; level=0; outputs 0 during reset.
- Hold velocity=0, let elapsed reach 40, switch velocity=3 (P=48) -> pulse at tick 48 of the period, not 75 and not skipped; at elapsed=60 switch to velocity=3 -> pulse on the very next enabled edge.
- Toggle count_map low for 10 cycles mid-count -> elapsed frozen; pulse arrives 10 cycles later than an ungated run; no pulses while low.
- RAMP_TICKS=20 override, count 100 enabled ticks -> base_level steps 1, 2, 3 at ticks 20, 40, 60; stays 3; max_base=1 from tick 60; base=3 with velocity=3 gives level=6 (P=21).
- Assert restart in the same cycle as a would-be pulse -> no pulse; all state 0; restart also overrides count_map.
- With MAP_SCROLL_PWM_EN, PWM_PERIOD=1000: level 0 -> high for 35 of 1000 cycles; change to level 7 mid-frame -> current frame unchanged, next frame high for 105 cycles.
